// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default widths for the pipeline hazard/flush/halt controller.
package pipeline_ctrl_pkg;

  localparam int RW_W_DEF  = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  // One bit per pipeline register, used for both advance enables and clears.
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Datapath-to-controller bundle: hazard inputs in, per-stage enables and counters out.
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int RW_W  = RW_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic [RW_W-1:0]  id_rs, id_rt, ex_rw;
  logic             id_uses_rs, id_uses_rt;
  logic             ex_mem_read, ex_we, ex_branch_taken;
  logic             wb_syscall, resume;
  logic             pc_go, go_if_id, go_id_ex, go_ex_mem, go_mem_wb;
  logic             clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wb;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [31:0]      cycle_cnt;

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_we, ex_rw,
           ex_branch_taken, wb_syscall, resume,
    output pc_go, go_if_id, go_id_ex, go_ex_mem, go_mem_wb,
           clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wb,
           halted, stall_cnt, flush_cnt, cycle_cnt
  );

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_we, ex_rw,
           ex_branch_taken, wb_syscall, resume,
    input  pc_go, go_if_id, go_id_ex, go_ex_mem, go_mem_wb,
           clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wb,
           halted, stall_cnt, flush_cnt, cycle_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: EX load whose destination (not $0) feeds a source the ID instruction reads.
module hazard_detect #(
  parameter int RW_W = 4
) (
  input  logic [RW_W-1:0] id_rs,
  input  logic [RW_W-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            ex_mem_read,
  input  logic            ex_we,
  input  logic [RW_W-1:0] ex_rw,
  output logic            hazard
);
  logic rs_hit, rt_hit;

  assign rs_hit = id_uses_rs && (id_rs == ex_rw);
  assign rt_hit = id_uses_rt && (id_rt == ex_rw);
  assign hazard = ex_mem_read && ex_we && (ex_rw != '0) && (rs_hit || rt_hit);
endmodule

// File: rtl/pipeline_ctrl.sv
// RUN/HALT controller: combinational stage enables/clears, syscall halt, perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int RW_W  = RW_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  pipeline_ctrl_if.slave   bus
);
  state_t           state, state_nxt;
  stage_t           go, clr;
  logic             hazard, act, stall_evt, flush_evt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [31:0]      cycle_cnt;

  hazard_detect #(.RW_W(RW_W)) u_hzd (
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rs (bus.id_uses_rs),
    .id_uses_rt (bus.id_uses_rt),
    .ex_mem_read(bus.ex_mem_read),
    .ex_we      (bus.ex_we),
    .ex_rw      (bus.ex_rw),
    .hazard     (hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.wb_syscall) state_nxt = HALT;
      HALT:    if (bus.resume)     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // act: the RUN branch/stall/normal rules govern this cycle (syscall is ignored on resume).
  always_comb begin
    act = 1'b0;
    go  = '0;
    clr = '0;
    case (state)
      RUN:     act = !bus.wb_syscall;
      HALT:    act = bus.resume;
      default: act = 1'b0;
    endcase
    if (!rst_n) begin
      go = '1;
    end else if (act) begin
      if (bus.ex_branch_taken) begin
        go        = '1;
        clr.if_id = 1'b1;
        clr.id_ex = 1'b1;
      end else if (hazard) begin
        go.id_ex  = 1'b1;
        go.ex_mem = 1'b1;
        go.mem_wb = 1'b1;
        clr.id_ex = 1'b1;
      end else begin
        go = '1;
      end
      // Leaving HALT drains the held syscall out of MEM_WB.
      if (state == HALT) begin
        go.mem_wb  = 1'b1;
        clr.mem_wb = 1'b1;
      end
    end
  end

  assign flush_evt = act && bus.ex_branch_taken;
  assign stall_evt = act && !bus.ex_branch_taken && hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (state == RUN)                   cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign bus.pc_go      = go.pc;
  assign bus.go_if_id   = go.if_id;
  assign bus.go_id_ex   = go.id_ex;
  assign bus.go_ex_mem  = go.ex_mem;
  assign bus.go_mem_wb  = go.mem_wb;
  assign bus.clr_if_id  = clr.if_id;
  assign bus.clr_id_ex  = clr.id_ex;
  assign bus.clr_ex_mem = clr.ex_mem;
  assign bus.clr_mem_wb = clr.mem_wb;
  assign bus.halted     = (state == HALT);
  assign bus.stall_cnt  = stall_cnt;
  assign bus.flush_cnt  = flush_cnt;
  assign bus.cycle_cnt  = cycle_cnt;
endmodule
